// File: rtl/dds_tune_ctrl_pkg.sv
// Shared types and constants for the DDS tuning-word controller.
// Step sizes assume a 32-bit phase accumulator clocked at 12 MHz.
package dds_tune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_OFFER = 2'd2
    } tune_state_t;

    typedef logic [1:0] step_idx_t;

    // 1 Hz, 10 Hz, 100 Hz, 1 kHz expressed as FTW increments
    localparam logic [31:0] STEP_TABLE [4] = '{32'd358, 32'd3579, 32'd35791, 32'd357914};

    localparam int PEND_W_DEF = 3;

endpackage

// File: rtl/dds_tune_ctrl_if.sv
// FTW valid/ready handshake between the tuning controller and the phase accumulator.
interface dds_tune_ctrl_if #(
    parameter int FTW_W = 32
) ();
    logic [FTW_W-1:0] ftw_out;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (output ftw_out, output ftw_valid, input ftw_ready);
    modport slave  (input ftw_out, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/dds_tune_ctrl_press_pend_ctr.sv
// Saturating pending-press counter: +1 per press, -1 when the FSM consumes one.
// A press and a consume in the same cycle cancel.
module press_pend_ctr #(
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              take,
    output logic [PEND_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({inc, take})
                2'b10: if (cnt != '1) cnt <= cnt + 1'b1;
                2'b01: if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dds_tune_ctrl.sv
// Button-driven DDS tuning-word controller with queued presses and valid/ready output.
// Define DDS_TUNE_WRAP_EN for modulo-2^FTW_W tuning instead of saturating clamp.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | ftw_out held, waiting for a pending UP or DOWN press
//  ST_CALC  | consume one press (UP first), load clamped/wrapped FTW
//  ST_OFFER | ftw_valid high, ftw_out stable until ftw_ready
module dds_tune_ctrl
    import dds_tune_pkg::*;
#(
    parameter int               FTW_W    = 32,
    parameter logic [FTW_W-1:0] FTW_INIT = 357914,
    parameter logic [FTW_W-1:0] FTW_MIN  = 0,
    parameter logic [FTW_W-1:0] FTW_MAX  = 32'h7FFFFFFF,
    parameter int               PEND_W   = PEND_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_p,
    input  logic                   dn_p,
    input  logic                   step_p,
    dds_tune_ctrl_if.master        ftw_if,
    output step_idx_t              step_idx,
    output logic                   limit_hit
);

    tune_state_t       state_q;
    tune_state_t       state_d;

    logic [PEND_W-1:0] up_pend;
    logic [PEND_W-1:0] dn_pend;
    logic              up_nz;
    logic              dn_nz;
    logic              up_inc;
    logic              dn_inc;

    logic              calc_en;
    logic              up_take;
    logic              dn_take;
    logic              ftw_valid;

    logic [FTW_W-1:0]  ftw_q;
    logic [FTW_W-1:0]  ftw_next;
    logic [FTW_W-1:0]  step_w;
    logic              clamp;

    // Simultaneous UP and DOWN is ambiguous, so both are dropped
    assign up_inc = up_p & ~dn_p;
    assign dn_inc = dn_p & ~up_p;
    assign up_nz  = |up_pend;
    assign dn_nz  = |dn_pend;

    press_pend_ctr #(.PEND_W(PEND_W)) u_up_pend (
        .clk  (clk),
        .rst  (rst),
        .inc  (up_inc),
        .take (up_take),
        .cnt  (up_pend)
    );

    press_pend_ctr #(.PEND_W(PEND_W)) u_dn_pend (
        .clk  (clk),
        .rst  (rst),
        .inc  (dn_inc),
        .take (dn_take),
        .cnt  (dn_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (up_nz || dn_nz) state_d = ST_CALC;
            ST_CALC:  state_d = ST_OFFER;
            ST_OFFER: if (ftw_if.ftw_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        calc_en   = (state_q == ST_CALC);
        up_take   = calc_en & up_nz;
        dn_take   = calc_en & ~up_nz & dn_nz;
        ftw_valid = (state_q == ST_OFFER);
    end

    assign step_w = FTW_W'(STEP_TABLE[step_idx]);

`ifdef DDS_TUNE_WRAP_EN
    always_comb begin
        clamp    = 1'b0;
        ftw_next = up_take ? (ftw_q + step_w) : (ftw_q - step_w);
    end
`else
    logic [FTW_W:0] sum_up;
    logic [FTW_W:0] floor_lim;

    // One extra bit keeps overflow visible; DOWN is checked as ftw < MIN+step
    // so underflow and the lower limit are a single compare.
    assign sum_up    = {1'b0, ftw_q} + {1'b0, step_w};
    assign floor_lim = {1'b0, FTW_MIN} + {1'b0, step_w};

    always_comb begin
        clamp    = 1'b0;
        ftw_next = ftw_q;
        if (up_take) begin
            if (sum_up > {1'b0, FTW_MAX}) begin
                ftw_next = FTW_MAX;
                clamp    = 1'b1;
            end else begin
                ftw_next = sum_up[FTW_W-1:0];
            end
        end else begin
            if ({1'b0, ftw_q} < floor_lim) begin
                ftw_next = FTW_MIN;
                clamp    = 1'b1;
            end else begin
                ftw_next = ftw_q - step_w;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_q     <= FTW_INIT;
            limit_hit <= 1'b0;
        end else begin
            limit_hit <= calc_en & clamp;
            if (calc_en) ftw_q <= ftw_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         step_idx <= '0;
        else if (step_p) step_idx <= step_idx + 2'd1;
    end

    assign ftw_if.ftw_out   = ftw_q;
    assign ftw_if.ftw_valid = ftw_valid;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Directed bench for dds_tune_ctrl: table of single presses plus queued/reset/limit sequences.
// Expectations follow DDS_TUNE_WRAP_EN when it is defined for the build.
module tb_dds_tune_ctrl;

    localparam logic [31:0] INIT = 32'd357914;
    localparam logic [31:0] MAXV = 32'h7FFFFFFF;
    localparam int OP_UP = 0, OP_DN = 1, OP_STEP = 2;

    typedef struct {
        int          op;
        logic [31:0] exp_ftw;
        logic        exp_lim;
        logic [1:0]  exp_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_p = 1'b0, dn_p = 1'b0, step_p = 1'b0, ready = 1'b1;
    logic [1:0] step_idx;
    logic limit_hit;

    logic hi_up = 1'b0, hi_dn = 1'b0, hi_step = 1'b0, hi_ready = 1'b1;
    logic [1:0] hi_idx;
    logic hi_lim;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dds_tune_ctrl_if #(.FTW_W(32)) bus ();
    dds_tune_ctrl_if #(.FTW_W(32)) hi_bus ();
    assign bus.ftw_ready    = ready;
    assign hi_bus.ftw_ready = hi_ready;

    dds_tune_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .up_p      (up_p),
        .dn_p      (dn_p),
        .step_p    (step_p),
        .ftw_if    (bus),
        .step_idx  (step_idx),
        .limit_hit (limit_hit)
    );

    // Second instance starts just below the upper limit
    dds_tune_ctrl #(.FTW_INIT(32'h7FFFFF9B)) u_dut_hi (
        .clk       (clk),
        .rst       (rst),
        .up_p      (hi_up),
        .dn_p      (hi_dn),
        .step_p    (hi_step),
        .ftw_if    (hi_bus),
        .step_idx  (hi_idx),
        .limit_hit (hi_lim)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Caller is at a negedge; pulse lasts one cycle, returns at the next negedge
    task automatic press(input int btn);
        up_p   = (btn == OP_UP);
        dn_p   = (btn == OP_DN);
        step_p = (btn == OP_STEP);
        @(negedge clk);
        up_p = 1'b0; dn_p = 1'b0; step_p = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.ftw_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_offers(input int cycles, output int cnt, output logic [31:0] first,
                                output logic [31:0] last);
        cnt = 0; first = '0; last = '0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.ftw_valid) begin
                if (cnt == 0) first = bus.ftw_out;
                last = bus.ftw_out;
                cnt++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        int          n;
        int          cnt;
        logic [31:0] first, last, held;
        logic        stable;

        tbl[0]  = '{OP_UP,   32'd358272, 1'b0, 2'd0};
        tbl[1]  = '{OP_DN,   32'd357914, 1'b0, 2'd0};
        tbl[2]  = '{OP_STEP, 32'd0,      1'b0, 2'd1};
        tbl[3]  = '{OP_UP,   32'd361493, 1'b0, 2'd1};
        tbl[4]  = '{OP_DN,   32'd357914, 1'b0, 2'd1};
        tbl[5]  = '{OP_STEP, 32'd0,      1'b0, 2'd2};
        tbl[6]  = '{OP_STEP, 32'd0,      1'b0, 2'd3};
        tbl[7]  = '{OP_DN,   32'd0,      1'b0, 2'd3};
`ifdef DDS_TUNE_WRAP_EN
        tbl[8]  = '{OP_DN,   32'hFFFA89E6, 1'b0, 2'd3};
        tbl[9]  = '{OP_UP,   32'd0,        1'b0, 2'd3};
        tbl[10] = '{OP_STEP, 32'd0,        1'b0, 2'd0};
        tbl[11] = '{OP_UP,   32'd358,      1'b0, 2'd0};
`else
        tbl[8]  = '{OP_DN,   32'd0,      1'b1, 2'd3};
        tbl[9]  = '{OP_UP,   32'd357914, 1'b0, 2'd3};
        tbl[10] = '{OP_STEP, 32'd0,      1'b0, 2'd0};
        tbl[11] = '{OP_UP,   32'd358272, 1'b0, 2'd0};
`endif

        do_reset();
        check("rst_ftw",   bus.ftw_out, INIT);
        check("rst_valid", bus.ftw_valid, 1'b0);
        check("rst_idx",   step_idx, 2'd0);
        check("rst_lim",   limit_hit, 1'b0);

        ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            press(tbl[i].op);
            if (tbl[i].op == OP_STEP) begin
                check($sformatf("row%0d_idx", i), step_idx, tbl[i].exp_idx);
            end else begin
                wait_valid(n);
                check($sformatf("row%0d_latency", i), n, 2);
                check($sformatf("row%0d_ftw", i), bus.ftw_out, tbl[i].exp_ftw);
                check($sformatf("row%0d_lim", i), limit_hit, tbl[i].exp_lim);
                @(negedge clk);
                check($sformatf("row%0d_valid_drop", i), bus.ftw_valid, 1'b0);
                check($sformatf("row%0d_lim_drop", i), limit_hit, 1'b0);
            end
        end

        // Backlog under back-pressure: pending counter saturates at 7
        do_reset();
        ready = 1'b0;
        repeat (9) press(OP_UP);
        wait_valid(n);
        check("bp_valid", bus.ftw_valid, 1'b1);
        check("bp_ftw", bus.ftw_out, 32'd358272);
        held = bus.ftw_out;
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!bus.ftw_valid || bus.ftw_out !== held) stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1'b1);
        ready = 1'b1;
        count_offers(60, cnt, first, last);
        check("bp_further_offers", cnt, 7);
        check("bp_final_ftw", last, INIT + 32'd8 * 32'd358);

        // Simultaneous UP+DOWN is dropped; queued UP then DOWN returns to INIT
        do_reset();
        ready = 1'b1;
        up_p = 1'b1; dn_p = 1'b1;
        @(negedge clk);
        up_p = 1'b0; dn_p = 1'b0;
        count_offers(8, cnt, first, last);
        check("both_no_offer", cnt, 0);
        check("both_ftw", bus.ftw_out, INIT);
        press(OP_UP);
        press(OP_DN);
        count_offers(20, cnt, first, last);
        check("queue_offers", cnt, 2);
        check("queue_first", first, 32'd358272);
        check("queue_last", last, INIT);

        // Upper clamp on the instance seeded near FTW_MAX
        do_reset();
        hi_ready = 1'b1;
        repeat (3) begin
            hi_step = 1'b1;
            @(negedge clk);
            hi_step = 1'b0;
        end
        check("hi_idx", hi_idx, 2'd3);
        hi_up = 1'b1;
        @(negedge clk);
        hi_up = 1'b0;
        n = 0;
        while (!hi_bus.ftw_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hi_valid", hi_bus.ftw_valid, 1'b1);
`ifdef DDS_TUNE_WRAP_EN
        check("hi_ftw", hi_bus.ftw_out, 32'h7FFFFF9B + 32'd357914);
        check("hi_lim", hi_lim, 1'b0);
`else
        check("hi_ftw", hi_bus.ftw_out, MAXV);
        check("hi_lim", hi_lim, 1'b1);
`endif

        // Reset in the middle of an offer
        do_reset();
        ready = 1'b0;
        press(OP_STEP);
        press(OP_UP);
        wait_valid(n);
        check("mid_valid", bus.ftw_valid, 1'b1);
        check("mid_ftw", bus.ftw_out, INIT + 32'd3579);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", bus.ftw_valid, 1'b0);
        check("mid_rst_ftw", bus.ftw_out, INIT);
        check("mid_rst_idx", step_idx, 2'd0);
        check("mid_rst_lim", limit_hit, 1'b0);
        rst = 1'b0;
        ready = 1'b1;
        count_offers(10, cnt, first, last);
        check("mid_rst_no_pend", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
